// File: rtl/peripheral_apb4_requester_if.sv
// Command, response and APB4 bus signals of the requester.
// master: requester side; slave: producer/consumer/completer side.
interface peripheral_apb4_requester_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic                  cmd_write;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PWRITE;
  logic                  PSEL;
  logic                  PENABLE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_wdata,
    input  rsp_ready, PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output rsp_timeout, PADDR, PWRITE, PSEL, PENABLE,
    output PWDATA
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_wdata,
    output rsp_ready, PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  rsp_timeout, PADDR, PWRITE, PSEL, PENABLE,
    input  PWDATA
  );
endinterface

// File: rtl/peripheral_apb4_requester.sv
// Single-outstanding APB4 requester with wait-state timeout.
// Ports: PCLK, PRESETn (async low), bus (cmd/rsp/APB, master).
module peripheral_apb4_requester #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256,
  parameter int CNT_WIDTH  = 16
) (
  input logic PCLK,
  input logic PRESETn,
  peripheral_apb4_requester_if.master bus
);

  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_WIDTH-1:0] TLAST =
    CNT_WIDTH'(TO_EN ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE, SETUP, ACCESS, RESP
  } state_t;

  state_t state, state_d;

  logic [CNT_WIDTH-1:0]  cnt, cnt_d;
  logic [ADDR_WIDTH-1:0] paddr, paddr_d;
  logic                  pwrite, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata, pwdata_d;
  logic                  psel, psel_d;
  logic                  pen, pen_d;
  logic                  rvld, rvld_d;
  logic [DATA_WIDTH-1:0] rdata, rdata_d;
  logic                  rerr, rerr_d;
  logic                  rto, rto_d;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state  <= IDLE;
      cnt    <= '0;
      paddr  <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
      psel   <= 1'b0;
      pen    <= 1'b0;
      rvld   <= 1'b0;
      rdata  <= '0;
      rerr   <= 1'b0;
      rto    <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      paddr  <= paddr_d;
      pwrite <= pwrite_d;
      pwdata <= pwdata_d;
      psel   <= psel_d;
      pen    <= pen_d;
      rvld   <= rvld_d;
      rdata  <= rdata_d;
      rerr   <= rerr_d;
      rto    <= rto_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    paddr_d  = paddr;
    pwrite_d = pwrite;
    pwdata_d = pwdata;
    psel_d   = psel;
    pen_d    = pen;
    rvld_d   = rvld;
    rdata_d  = rdata;
    rerr_d   = rerr;
    rto_d    = rto;
    unique case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          paddr_d  = bus.cmd_addr;
          pwrite_d = bus.cmd_write;
          pwdata_d = bus.cmd_wdata;
          psel_d   = 1'b1;
          pen_d    = 1'b0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        pen_d   = 1'b1;
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (bus.PREADY) begin
          psel_d  = 1'b0;
          pen_d   = 1'b0;
          rdata_d = pwrite ? '0 : bus.PRDATA;
          rerr_d  = bus.PSLVERR;
          rto_d   = 1'b0;
          rvld_d  = 1'b1;
          state_d = RESP;
        end else if (TO_EN && cnt == TLAST) begin
          // Abandon the completer mid-transfer.
          psel_d  = 1'b0;
          pen_d   = 1'b0;
          rdata_d = '0;
          rerr_d  = 1'b1;
          rto_d   = 1'b1;
          rvld_d  = 1'b1;
          state_d = RESP;
        end else if (cnt != '1) begin
          cnt_d = cnt + 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rvld_d  = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
  end

  assign bus.cmd_ready   = (state == IDLE);
  assign bus.PADDR       = paddr;
  assign bus.PWRITE      = pwrite;
  assign bus.PWDATA      = pwdata;
  assign bus.PSEL        = psel;
  assign bus.PENABLE     = pen;
  assign bus.rsp_valid   = rvld;
  assign bus.rsp_rdata   = rdata;
  assign bus.rsp_err     = rerr;
  assign bus.rsp_timeout = rto;

endmodule

// File: tb/tb_peripheral_apb4_requester.sv
// Directed bench for the APB4 requester (TIMEOUT=8).
// Vector table plus backpressure and reset sequences.
module tb_peripheral_apb4_requester;

  logic pclk;
  logic presetn;
  int   tests = 0;
  int   fails = 0;

  peripheral_apb4_requester_if #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32)
  ) bus ();

  peripheral_apb4_requester #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .TIMEOUT(8), .CNT_WIDTH(16)
  ) dut (
    .PCLK(pclk),
    .PRESETn(presetn),
    .bus(bus)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          waits;
    logic        werr;
    logic        err;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_acc;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h",
               name, act, exp);
    end
  endtask

  // Starts and ends at a negedge with the requester idle.
  task automatic xfer(input vec_t v);
    int n;
    logic done;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = v.addr;
    bus.cmd_write = v.wr;
    bus.cmd_wdata = v.wdata;
    bus.PREADY    = 1'b1;
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    @(negedge pclk);
    chk("setup_psel", bus.PSEL, 1);
    chk("setup_penable", bus.PENABLE, 0);
    chk("setup_paddr", bus.PADDR, v.addr);
    chk("setup_pwrite", bus.PWRITE, v.wr);
    chk("setup_pwdata", bus.PWDATA, v.wdata);
    chk("setup_cmd_ready", bus.cmd_ready, 0);
    bus.cmd_valid = 1'b0;
    bus.PREADY    = 1'b1;
    bus.PSLVERR   = 1'b1;
    @(negedge pclk);
    n = 0;
    while (bus.PSEL && bus.PENABLE && n < 40) begin
      n++;
      chk("access_paddr", bus.PADDR, v.addr);
      done = (n > v.waits);
      bus.PREADY  = done;
      bus.PSLVERR = done ? v.err : v.werr;
      bus.PRDATA  = done ? v.prdata : 32'hBAD0_0000 + n;
      @(negedge pclk);
    end
    chk("access_cycles", n, v.exp_acc);
    chk("rsp_psel", bus.PSEL, 0);
    chk("rsp_penable", bus.PENABLE, 0);
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_rdata", bus.rsp_rdata, v.exp_rdata);
    chk("rsp_err", bus.rsp_err, v.exp_err);
    chk("rsp_timeout", bus.rsp_timeout, v.exp_to);
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    @(negedge pclk);
    chk("pop_rsp_valid", bus.rsp_valid, 0);
    chk("pop_cmd_ready", bus.cmd_ready, 1);
  endtask

  initial begin
    vec_t rv;
    vecs[0] = '{1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 0,
                1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1};
    vecs[1] = '{1'b0, 32'h20, 32'h0, 32'h1234_5678, 3,
                1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 4};
    vecs[2] = '{1'b0, 32'h30, 32'h0, 32'h5555_0000, 2,
                1'b1, 1'b1, 32'h5555_0000, 1'b1, 1'b0, 3};
    vecs[3] = '{1'b0, 32'h40, 32'h0, 32'hA5A5_A5A5, 2,
                1'b1, 1'b0, 32'hA5A5_A5A5, 1'b0, 1'b0, 3};
    vecs[4] = '{1'b1, 32'h50, 32'h0BAD_F00D, 32'hFFFF, 7,
                1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 8};
    vecs[5] = '{1'b0, 32'h60, 32'h0, 32'h7777_7777, 99,
                1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 8};
    vecs[6] = '{1'b1, 32'h64, 32'h0102_0304, 32'h9, 1,
                1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 2};

    presetn       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_write = 1'b0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;
    repeat (3) @(negedge pclk);
    chk("rst_psel", bus.PSEL, 0);
    chk("rst_penable", bus.PENABLE, 0);
    chk("rst_paddr", bus.PADDR, 0);
    chk("rst_pwrite", bus.PWRITE, 0);
    chk("rst_pwdata", bus.PWDATA, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_rsp_timeout", bus.rsp_timeout, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    presetn       = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge pclk);

    for (int i = 0; i < 7; i++) begin
      xfer(vecs[i]);
      if (i == 5) begin
        // Late PREADY after the timeout abort.
        bus.PREADY = 1'b1;
        for (int k = 0; k < 2; k++) begin
          @(negedge pclk);
          chk("late_rsp_valid", bus.rsp_valid, 0);
          chk("late_psel", bus.PSEL, 0);
        end
        bus.PREADY = 1'b0;
        @(negedge pclk);
      end
    end

    // Backpressure with a second command held early.
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 32'h70;
    bus.cmd_write = 1'b0;
    bus.cmd_wdata = 32'h0;
    bus.PREADY    = 1'b1;
    bus.PRDATA    = 32'hCAFE_F00D;
    bus.PSLVERR   = 1'b0;
    @(negedge pclk);
    chk("bp_setup_paddr", bus.PADDR, 32'h70);
    bus.cmd_addr  = 32'h80;
    bus.cmd_write = 1'b1;
    bus.cmd_wdata = 32'h1122_3344;
    @(negedge pclk);
    chk("bp_access_paddr", bus.PADDR, 32'h70);
    chk("bp_access_penable", bus.PENABLE, 1);
    @(negedge pclk);
    bus.PRDATA = 32'h0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      chk("bp_rsp_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
      chk("bp_rsp_err", bus.rsp_err, 0);
      chk("bp_cmd_ready", bus.cmd_ready, 0);
      chk("bp_psel", bus.PSEL, 0);
      @(negedge pclk);
    end
    chk("bp_hold_valid", bus.rsp_valid, 1);
    bus.rsp_ready = 1'b1;
    @(negedge pclk);
    chk("bp_pop_valid", bus.rsp_valid, 0);
    chk("bp_pop_cmd_ready", bus.cmd_ready, 1);
    @(negedge pclk);
    chk("b2b_psel", bus.PSEL, 1);
    chk("b2b_penable", bus.PENABLE, 0);
    chk("b2b_paddr", bus.PADDR, 32'h80);
    chk("b2b_pwdata", bus.PWDATA, 32'h1122_3344);
    bus.cmd_valid = 1'b0;
    @(negedge pclk);
    chk("b2b_access", bus.PENABLE, 1);
    @(negedge pclk);
    chk("b2b_rsp_valid", bus.rsp_valid, 1);
    chk("b2b_rsp_rdata", bus.rsp_rdata, 0);
    bus.PREADY = 1'b0;
    @(negedge pclk);
    chk("b2b_idle", bus.cmd_ready, 1);

    // Reset in the middle of an ACCESS wait.
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 32'h90;
    bus.cmd_write = 1'b0;
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    @(negedge pclk);
    chk("mr_penable", bus.PENABLE, 1);
    @(negedge pclk);
    #2 presetn = 1'b0;
    #1;
    chk("mr_psel", bus.PSEL, 0);
    chk("mr_penable_rst", bus.PENABLE, 0);
    chk("mr_rsp_valid", bus.rsp_valid, 0);
    chk("mr_paddr", bus.PADDR, 0);
    chk("mr_cmd_ready", bus.cmd_ready, 1);
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    chk("mr_no_rsp", bus.rsp_valid, 0);
    rv = '{1'b0, 32'hA0, 32'h0, 32'h0BEE_F123, 1,
           1'b0, 1'b0, 32'h0BEE_F123, 1'b0, 1'b0, 2};
    xfer(rv);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
